// File: rtl/dac128_pkg.sv
// Shared constants, FSM state type and code saturation helper for the
// 128-cell unary current DAC front end.
package dac128_pkg;

  localparam int N_CELLS    = 128;
  localparam int CODE_W     = 8;
  localparam int N_GRP      = 4;
  localparam int SETTLE_CYC = 16;

  localparam int PTR_W = $clog2(N_CELLS);
  // Active-cell count must hold 0..N_CELLS inclusive.
  localparam int CNT_W = $clog2(N_CELLS + 1);
  // Group counter holds 0..N_GRP inclusive.
  localparam int GRP_W = $clog2(N_GRP + 1);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  // Clamp a requested code to the number of physical cells.
  function automatic logic [CNT_W-1:0] sat_code(input logic [CODE_W-1:0] code);
    logic [CNT_W-1:0] res;
    if (int'(code) > N_CELLS) begin
      res = CNT_W'(N_CELLS);
    end else begin
      res = CNT_W'(code);
    end
    return res;
  endfunction

endpackage

// File: rtl/dac128_rot_therm.sv
// Combinational cell-mask generator: plain thermometer or DWA rotation
// starting at the current pointer, plus the pointer for the next code.
module dac128_rot_therm
  import dac128_pkg::*;
(
  input  logic [PTR_W-1:0]   ptr,
  input  logic [CNT_W-1:0]   cnt,
  input  logic               dwa,
  output logic [N_CELLS-1:0] mask,
  output logic [PTR_W-1:0]   ptr_next
);

  logic [N_CELLS-1:0]   therm_s;
  logic [2*N_CELLS-1:0] dbl_s;

  // Build the thermometer pattern, then rotate it by ptr when DWA is selected.
  // The doubled vector turns a left shift into a circular rotation: the upper
  // half collects both the in-range bits and the bits that wrapped past the top.
  always_comb begin
    therm_s = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      therm_s[i] = (CNT_W'(i) < cnt);
    end
    dbl_s = {therm_s, therm_s} << ptr;
    if (dwa) begin
      mask     = dbl_s[2*N_CELLS-1:N_CELLS];
      // cnt == N_CELLS drops out of the low bits, leaving the pointer unchanged.
      ptr_next = ptr + cnt[PTR_W-1:0];
    end else begin
      mask     = therm_s;
      ptr_next = ptr;
    end
  end

endmodule

// File: rtl/dac128_driver.sv
// Digital front end for the 128-cell unary current DAC: code handshake,
// registered complementary cell switches with optional DWA rotation, and
// bias-group power-up/power-down sequencing.
module dac128_driver
  import dac128_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               mode_dwa_i,
  input  logic [CODE_W-1:0]  code_i,
  input  logic               code_valid_i,
  output logic               code_ready_o,
  output logic [N_CELLS-1:0] on_o,
  output logic [N_CELLS-1:0] onb_o,
  output logic [N_GRP-1:0]   en_o,
  output logic [N_GRP-1:0]   enb_o,
  output logic               running_o,
  output logic [PTR_W-1:0]   ptr_o
);

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [GRP_W-1:0] GRP_ALL  = GRP_W'(N_GRP);

  state_t             state_r, state_s;
  logic [GRP_W-1:0]   g_r, g_s;
  logic [SET_W-1:0]   s_r, s_s;
  logic [N_GRP-1:0]   en_r, en_s;
  logic [N_GRP-1:0]   enb_r;
  logic [N_CELLS-1:0] on_r, on_s;
  logic [N_CELLS-1:0] onb_r;
  logic [PTR_W-1:0]   ptr_r, ptr_s;
  logic               ready_r;
  logic               running_r;

  logic               accept_s;
  logic [CNT_W-1:0]   cnt_s;
  logic [N_CELLS-1:0] mask_s;
  logic [PTR_W-1:0]   ptr_next_s;

  // ready_r is high exactly while the FSM sits in RUN.
  assign accept_s = ready_r & code_valid_i;
  assign cnt_s    = sat_code(code_i);

  dac128_rot_therm u_rot_therm (
    .ptr      (ptr_r),
    .cnt      (cnt_s),
    .dwa      (mode_dwa_i),
    .mask     (mask_s),
    .ptr_next (ptr_next_s)
  );

  // Next-state, counter, bias-enable and cell-mask decisions.
  always_comb begin
    state_s = state_r;
    g_s     = g_r;
    s_s     = s_r;
    en_s    = en_r;
    on_s    = on_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_OFF: begin
        if (enable_i) begin
          state_s = ST_RAMP;
          g_s     = '0;
          s_s     = '0;
        end else begin
          state_s = ST_OFF;
        end
      end
      ST_RAMP: begin
        if (!enable_i) begin
          state_s = ST_DOWN;
          s_s     = '0;
        end else if (s_r == SET_LAST) begin
          s_s = '0;
          if (g_r == GRP_ALL) begin
            // All groups on and one extra settle period elapsed.
            state_s = ST_RUN;
          end else begin
            en_s = en_r | (N_GRP'(1) << g_r);
            g_s  = g_r + GRP_W'(1);
          end
        end else begin
          s_s = s_r + SET_W'(1);
        end
      end
      ST_RUN: begin
        // A code accepted on the enable-fall cycle is still applied; DOWN clears it next.
        if (accept_s) begin
          on_s  = mask_s;
          ptr_s = ptr_next_s;
        end else begin
          on_s  = on_r;
        end
        if (!enable_i) begin
          state_s = ST_DOWN;
          s_s     = '0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DOWN: begin
        on_s = '0;
        if (g_r == '0) begin
          state_s = ST_OFF;
        end else if (s_r == SET_LAST) begin
          // Groups come down in reverse order: highest set bit first.
          en_s = en_r & ~(N_GRP'(1) << (g_r - GRP_W'(1)));
          g_s  = g_r - GRP_W'(1);
          s_s  = '0;
        end else begin
          s_s = s_r + SET_W'(1);
        end
      end
      default: begin
        state_s = ST_OFF;
        g_s     = '0;
        s_s     = '0;
        en_s    = '0;
        on_s    = '0;
      end
    endcase
  end

  // State, counters and all output flops; complements are flopped, never decoded after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_OFF;
      g_r       <= '0;
      s_r       <= '0;
      en_r      <= '0;
      enb_r     <= '1;
      on_r      <= '0;
      onb_r     <= '1;
      ptr_r     <= '0;
      ready_r   <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      g_r       <= g_s;
      s_r       <= s_s;
      en_r      <= en_s;
      enb_r     <= ~en_s;
      on_r      <= on_s;
      onb_r     <= ~on_s;
      ptr_r     <= ptr_s;
      ready_r   <= (state_s == ST_RUN);
      running_r <= (state_s == ST_RUN);
    end
  end

  assign code_ready_o = ready_r;
  assign running_o    = running_r;
  assign on_o         = on_r;
  assign onb_o        = onb_r;
  assign en_o         = en_r;
  assign enb_o        = enb_r;
  assign ptr_o        = ptr_r;

endmodule

// File: tb/tb_dac128_driver.sv
// Self-checking bench for dac128_driver: ramp/down sequencing, thermometer
// and DWA codes checked through an expected-value scoreboard, handshake, reset.
module tb_dac128_driver;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable_i;
  logic         mode_dwa_i;
  logic [7:0]   code_i;
  logic         code_valid_i;
  logic         code_ready_o;
  logic [127:0] on_o;
  logic [127:0] onb_o;
  logic [3:0]   en_o;
  logic [3:0]   enb_o;
  logic         running_o;
  logic [6:0]   ptr_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_on_q[$];
  logic [6:0]   exp_ptr_q[$];
  int           exp_cnt_q[$];
  logic [127:0] last_on;
  logic [6:0]   model_ptr = 7'd0;

  dac128_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .mode_dwa_i   (mode_dwa_i),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .code_ready_o (code_ready_o),
    .on_o         (on_o),
    .onb_o        (onb_o),
    .en_o         (en_o),
    .enb_o        (enb_o),
    .running_o    (running_o),
    .ptr_o        (ptr_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic chk_inv();
    logic [3:0]   inv_en;
    logic [127:0] inv_on;
    inv_en = ~en_o;
    inv_on = ~on_o;
    chk_eq("enb_inv", enb_o, inv_en);
    chk_eq("onb_inv", onb_o, inv_on);
  endtask

  // Present one code for one edge, push the expected result, then pop and compare.
  task automatic send(input int code, input bit dwa);
    int           c;
    logic [127:0] m;
    c = (code > 128) ? 128 : code;
    m = '0;
    for (int k = 0; k < c; k++) begin
      if (dwa) m[(int'(model_ptr) + k) % 128] = 1'b1;
      else     m[k] = 1'b1;
    end
    if (dwa) model_ptr = 7'((int'(model_ptr) + c) % 128);
    exp_on_q.push_back(m);
    exp_ptr_q.push_back(model_ptr);
    exp_cnt_q.push_back(c);
    code_i       = 8'(code);
    mode_dwa_i   = dwa;
    code_valid_i = 1'b1;
    @(posedge clk); #1;
    code_valid_i = 1'b0;
    last_on = exp_on_q.pop_front();
    chk_eq($sformatf("on_code%0d", code), on_o, last_on);
    chk_eq($sformatf("ptr_code%0d", code), ptr_o, exp_ptr_q.pop_front());
    chk_eq($sformatf("pop_code%0d", code), $countones(on_o), exp_cnt_q.pop_front());
    chk_inv();
  endtask

  initial begin
    int           cyc;
    int           idx;
    logic [3:0]   prev;
    int           last;
    logic [3:0]   ramp_val[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [3:0]   down_val[5] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0001};
    int           down_cyc[5] = '{16, 32, 48, 64, 82};
    logic [127:0] all1 = {128{1'b1}};

    rst_n = 1'b0; enable_i = 1'b0; mode_dwa_i = 1'b0; code_i = 8'd0; code_valid_i = 1'b0;
    #23;
    chk_eq("rst_on", on_o, 128'd0);
    chk_eq("rst_onb", onb_o, all1);
    chk_eq("rst_en", en_o, 4'b0000);
    chk_eq("rst_enb", enb_o, 4'b1111);
    chk_eq("rst_ready", code_ready_o, 1'b0);
    chk_eq("rst_running", running_o, 1'b0);
    chk_eq("rst_ptr", ptr_o, 7'd0);
    @(negedge clk); rst_n = 1'b1;

    // Power-up ramp, with a code held valid that must not be accepted.
    @(posedge clk); #1;
    enable_i = 1'b1; code_valid_i = 1'b1; code_i = 8'd50;
    cyc = 0; idx = 0; prev = 4'b0000; last = 0;
    while (!code_ready_o && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      chk_inv();
      if (en_o != prev) begin
        if (idx < 4) begin
          chk_eq($sformatf("ramp_val%0d", idx), en_o, ramp_val[idx]);
          chk_eq($sformatf("ramp_cyc%0d", idx), cyc - last, (idx == 0) ? 17 : 16);
        end else begin
          chk_eq("ramp_extra_step", en_o, prev);
        end
        prev = en_o; last = cyc; idx++;
      end
    end
    code_valid_i = 1'b0;
    chk_eq("ramp_steps", idx, 4);
    chk_eq("ready_after_1111", cyc - last, 16);
    chk_eq("running_up", running_o, 1'b1);
    chk_eq("ramp_no_accept", on_o, 128'd0);

    // Thermometer codes.
    send(0, 1'b0);
    send(1, 1'b0);
    send(64, 1'b0);
    send(128, 1'b0);
    send(200, 1'b0);
    // DWA wrap.
    send(100, 1'b1);
    send(60, 1'b1);
    send(128, 1'b1);

    // Hold: no valid for 20 cycles, code_i wiggling.
    for (int i = 0; i < 20; i++) begin
      code_i = 8'(i * 7);
      @(posedge clk); #1;
    end
    chk_eq("hold_on", on_o, last_on);
    chk_eq("hold_ptr", ptr_o, model_ptr);

    // Accept on the same cycle enable falls, then power down with re-enable.
    enable_i = 1'b0;
    send(10, 1'b0);
    cyc = 0; idx = 0; prev = en_o;
    while (idx < 5 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) chk_eq("down_on_clear", on_o, 128'd0);
      chk_inv();
      if (en_o != prev) begin
        chk_eq($sformatf("down_val%0d", idx), en_o, down_val[idx]);
        chk_eq($sformatf("down_cyc%0d", idx), cyc, down_cyc[idx]);
        if (idx == 0) enable_i = 1'b1;
        prev = en_o; idx++;
      end
      if (cyc == 66) chk_eq("off_not_running", running_o, 1'b0);
    end
    chk_eq("down_steps", idx, 5);

    // Back to RUN, move the pointer, then async reset mid-cycle.
    cyc = 0;
    while (!code_ready_o && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk_eq("rerun_ready", code_ready_o, 1'b1);
    send(5, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_on", on_o, 128'd0);
    chk_eq("arst_onb", onb_o, all1);
    chk_eq("arst_en", en_o, 4'b0000);
    chk_eq("arst_enb", enb_o, 4'b1111);
    chk_eq("arst_ready", code_ready_o, 1'b0);
    chk_eq("arst_running", running_o, 1'b0);
    chk_eq("arst_ptr", ptr_o, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
